// File: rtl/div_clk_monitor_pkg.sv
// Shared constants and types for the slow-clock monitor.
// Holds state encoding plus default half-period/tolerance, derived the same
// way the clock divider derives its toggle rate.
package div_clk_monitor_pkg;

  localparam int CLK_HZ  = 50_000_000;
  localparam int SLOW_HZ = 100;

  // The divider toggles twice per slow period, so one half-period is
  // CLK_HZ / (2 * SLOW_HZ) system clocks.
  localparam int DEF_NOM_HALF = CLK_HZ / (2 * SLOW_HZ);
  localparam int DEF_TOL      = 1024;
  localparam int DEF_LOCK_CNT = 4;
  localparam int DEF_CNT_W    = 25;
  localparam int DEF_ERR_W    = 8;

  localparam logic [1:0] ST_ACQUIRE = 2'd0;
  localparam logic [1:0] ST_LOCKED  = 2'd1;
  localparam logic [1:0] ST_LOST    = 2'd2;

  typedef enum logic [1:0] {
    ACQUIRE = ST_ACQUIRE,
    LOCKED  = ST_LOCKED,
    LOST    = ST_LOST
  } state_t;

  // Inclusive window test used to classify a measured half-period.
  function automatic logic in_window(input logic [31:0] val,
                                     input int          lo,
                                     input int          hi);
    return (val >= $unsigned(lo)) && (val <= $unsigned(hi));
  endfunction

endpackage

// File: rtl/div_clk_monitor_if.sv
// Bundle between the divided-clock monitor and its consumers.
// master: monitor side (takes slow_in, drives ticks/status/measurements);
// slave: consumer side (drives slow_in, observes everything else).
interface div_clk_monitor_if
  import div_clk_monitor_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int ERR_W = DEF_ERR_W
);

  logic             slow_in;
  logic             tick_rise;
  logic             tick_fall;
  logic             locked;
  logic             lost;
  logic [CNT_W-1:0] half_period;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    input  slow_in,
    output tick_rise,
    output tick_fall,
    output locked,
    output lost,
    output half_period,
    output err_cnt
  );

  modport slave (
    output slow_in,
    input  tick_rise,
    input  tick_fall,
    input  locked,
    input  lost,
    input  half_period,
    input  err_cnt
  );

endinterface

// File: rtl/div_clk_monitor_edge_sync.sv
// Synchronises the slow toggle into clk and flags each transition.
// Ports: clk/rst; slow_in (async); edge_det (combinational, one cycle per
// transition); tick_rise/tick_fall (registered one-cycle strobes).
module div_clk_monitor_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic slow_in,
  output logic edge_det,
  output logic tick_rise,
  output logic tick_fall
);

  logic       s1;
  logic       s2;
  logic       s3;
  logic [1:0] arm_sr;
  logic       arm;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      s3        <= 1'b0;
      arm_sr    <= 2'b00;
      arm       <= 1'b0;
      tick_rise <= 1'b0;
      tick_fall <= 1'b0;
    end else begin
      s1        <= slow_in;
      s2        <= s1;
      s3        <= s2;
      // arm comes up on the same edge that s3 first holds a post-reset
      // sample, so the level present at release never reads as an edge.
      arm_sr    <= {arm_sr[0], 1'b1};
      arm       <= arm | arm_sr[1];
      tick_rise <= edge_det & s2;
      tick_fall <= edge_det & ~s2;
    end
  end

  assign edge_det = arm & (s2 ^ s3);

endmodule

// File: rtl/div_clk_monitor.sv
// Measures each half-period of the divided clock and tracks lock/loss.
// Ports: clk, rst (sync, active-high) plus a master-side monitor bundle
// carrying slow_in, tick strobes, locked/lost, half_period and err_cnt.
module div_clk_monitor
  import div_clk_monitor_pkg::*;
#(
  parameter int NOM_HALF = DEF_NOM_HALF,
  parameter int TOL      = DEF_TOL,
  parameter int LOCK_CNT = DEF_LOCK_CNT,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int ERR_W    = DEF_ERR_W
) (
  input logic               clk,
  input logic               rst,
  div_clk_monitor_if.master bus
);

  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0]  TO_LIM    = CNT_W'(NOM_HALF + TOL + 1);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CNT - 1);

  logic              edge_det;
  logic              tick_rise;
  logic              tick_fall;
  logic [CNT_W-1:0]  cnt;
  logic              ref_vld;
  logic [GOOD_W-1:0] good_cnt;
  logic [GOOD_W-1:0] good_nxt;
  state_t            state;
  state_t            state_nxt;
  logic              err_inc;
  logic              meas_vld;
  logic              meas_good;
  logic              timeout;
  logic [CNT_W-1:0]  half_period;
  logic [ERR_W-1:0]  err_cnt;

  div_clk_monitor_edge_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .slow_in   (bus.slow_in),
    .edge_det  (edge_det),
    .tick_rise (tick_rise),
    .tick_fall (tick_fall)
  );

  // An edge only yields a measurement when a previous edge anchors cnt;
  // the first edge after reset or after losing the clock just restarts it.
  assign meas_vld  = edge_det & ref_vld;
  assign meas_good = in_window(32'(cnt), NOM_HALF - TOL, NOM_HALF + TOL);
  assign timeout   = (cnt >= TO_LIM);

  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    err_inc   = 1'b0;
    case (state)
      ACQUIRE: begin
        if (meas_vld) begin
          if (meas_good) begin
            if (good_cnt == GOOD_LAST) begin
              state_nxt = LOCKED;
              good_nxt  = '0;
            end else begin
              good_nxt = good_cnt + 1'b1;
            end
          end else begin
            good_nxt = '0;
          end
        end
      end
      LOCKED: begin
        // An edge coinciding with the timeout threshold is classified
        // normally rather than declared a loss.
        if (edge_det) begin
          if (!meas_good) begin
            state_nxt = ACQUIRE;
            good_nxt  = '0;
            err_inc   = 1'b1;
          end
        end else if (timeout) begin
          state_nxt = LOST;
          good_nxt  = '0;
          err_inc   = 1'b1;
        end
      end
      LOST: begin
        good_nxt = '0;
        if (edge_det) begin
          state_nxt = ACQUIRE;
        end
      end
      default: begin
        state_nxt = ACQUIRE;
        good_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ACQUIRE;
      good_cnt    <= '0;
      cnt         <= '0;
      ref_vld     <= 1'b0;
      half_period <= '0;
      err_cnt     <= '0;
    end else begin
      state    <= state_nxt;
      good_cnt <= good_nxt;

      if (edge_det) begin
        cnt <= CNT_W'(1);
      end else if (cnt != '1) begin
        cnt <= cnt + 1'b1;
      end

      if (meas_vld) begin
        half_period <= cnt;
      end

      if (state_nxt == LOST) begin
        ref_vld <= 1'b0;
      end else if (edge_det) begin
        ref_vld <= 1'b1;
      end

      if (err_inc && (err_cnt != '1)) begin
        err_cnt <= err_cnt + 1'b1;
      end
    end
  end

  assign bus.tick_rise   = tick_rise;
  assign bus.tick_fall   = tick_fall;
  assign bus.locked      = (state == LOCKED);
  assign bus.lost        = (state == LOST);
  assign bus.half_period = half_period;
  assign bus.err_cnt     = err_cnt;

endmodule
